// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle RV32I control sequencer with ready handshake, timeout and illegal-opcode fault
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [6:0]           op_i,
  input  logic                 mem_ready_i,
  input  logic                 stall_i,
  output logic                 pc_en_o,
  output logic                 ir_en_o,
  output logic                 memRead_en_o,
  output logic                 memWrite_en_o,
  output logic                 regWrite_en_o,
  output logic [2:0]           state_o,
  output logic                 fault_o,
  output logic                 instr_retired_o,
  output logic [CNT_WIDTH-1:0] retire_count_o
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    FAULT     = 3'd7
  } state_t;
  state_t               state_q, state_d, nxt;
  logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0] retire_count_q, retire_count_d;
  logic                 fault_q, fault_d;
  logic                 is_load, is_store, is_branch, legal, timeout, go;
  logic                 pc_en, ir_en, rd_en, wr_en, rw_en, ret;
  assign is_load   = op_i == 7'b0000011;
  assign is_store  = op_i == 7'b0100011;
  assign is_branch = op_i == 7'b1100011;
  assign legal     = op_i inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                  7'b1100111, 7'b1101111, 7'b0010111, 7'b0110111};
  assign timeout   = (wait_cnt_q == WW'(MEM_TIMEOUT - 1)) && !mem_ready_i;
  assign go        = !stall_i && !rst_i;
  // Per-state strobes and successor, before stall/reset gating
  always_comb begin
    nxt   = state_q;
    pc_en = 1'b0;
    ir_en = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    rw_en = 1'b0;
    ret   = 1'b0;
    case (state_q)
      FETCH: begin
        rd_en = 1'b1;
        ir_en = mem_ready_i;
        nxt   = mem_ready_i ? DECODE : timeout ? FAULT : FETCH;
      end
      DECODE: nxt = legal ? EXECUTE : FAULT;
      EXECUTE: begin
        pc_en = is_branch;
        ret   = is_branch;
        nxt   = (is_load || is_store) ? MEMORY : is_branch ? FETCH : WRITEBACK;
      end
      MEMORY: begin
        rd_en = is_load;
        wr_en = !is_load;
        pc_en = !is_load && mem_ready_i;
        ret   = !is_load && mem_ready_i;
        nxt   = mem_ready_i ? (is_load ? WRITEBACK : FETCH) : timeout ? FAULT : MEMORY;
      end
      WRITEBACK: begin
        rw_en = 1'b1;
        pc_en = 1'b1;
        ret   = 1'b1;
        nxt   = FETCH;
      end
      default: nxt = FAULT;
    endcase
  end
  // Stall freezes state and wait counter; wait counter restarts on any state change
  always_comb begin
    state_d        = go ? nxt : state_q;
    wait_cnt_d     = !go ? wait_cnt_q :
                     (nxt != state_q) ? '0 :
                     (state_q == FETCH || state_q == MEMORY) ? wait_cnt_q + WW'(1) : wait_cnt_q;
    retire_count_d = retire_count_q + CNT_WIDTH'(instr_retired_o);
    fault_d        = state_d == FAULT;
  end
  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= FETCH;
      wait_cnt_q     <= '0;
      retire_count_q <= '0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      retire_count_q <= retire_count_d;
      fault_q        <= fault_d;
    end
  end
  assign pc_en_o         = pc_en && go;
  assign ir_en_o         = ir_en && go;
  assign memRead_en_o    = rd_en && go;
  assign memWrite_en_o   = wr_en && go;
  assign regWrite_en_o   = rw_en && go;
  assign instr_retired_o = ret && go;
  assign state_o         = state_q;
  assign fault_o         = fault_q;
  assign retire_count_o  = retire_count_q;
endmodule
